hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. Each cycle it drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC stall. It resolves these hazards in a fixed priority:
- data-memory wait
- multi-cycle mul/div occupancy of EX
- taken branch
- load-use
- instruction-memory wait

It also keeps saturating stall and flush event counters for performance analysis.

## Interface
- MULDIV_LAT, 4: total cycles a mul/div instruction occupies EX; must be ≥1.
- CNT_W, 32: width of the performance counters.

- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2.
- ex_mem_read  in  1  EX holds a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_muldiv  in  1  EX holds a mul/div instruction; held high while it is stalled in EX.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- imem_ready  in  1  fetch data is valid this cycle.
- mem_access  in  1  MEM holds a load or store.
- dmem_ready  in  1  data memory completes this cycle.
- pc_stall  out  1  hold the PC.
- if_id_stall, if_id_flush  out  1 each  IF/ID controls.
- id_ex_stall, id_ex_flush  out  1 each  ID/EX controls.
- ex_mem_stall, ex_mem_flush  out  1 each  EX/MEM controls.
- mem_wb_flush  out  1  insert a bubble into MEM/WB.
- muldiv_done  out  1  last EX cycle of a mul/div; its result advances.
- stall_cnt  out  CNT_W  number of cycles with pc_stall=1.
- flush_cnt  out  CNT_W  number of branch flushes.

## Operation
- State is `{RUN, MULDIV}`, plus `cnt` (`$clog2(MULDIV_LAT)+1` bits), plus a `kill_pending` flag.
- The control outputs are combinational from the current state and inputs. Every output not named in an active rule is 0.
- Rules are evaluated in priority order. The first matching rule sets the controls, except that rule 5 may combine with rules 3 and 4 as noted.
  1. DMEM wait (`mem_access && !dmem_ready`):
     - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1.
     - FSM, `cnt` and `kill_pending` are frozen; branch and load-use are ignored.
  2. MULDIV stall:
     - Applies in RUN with `ex_muldiv=1` and MULDIV_LAT>1, or in MULDIV with `cnt≠0`.
     - pc_stall, if_id_stall, id_ex_stall = 1; ex_mem_flush = 1.
     - RUN entry: `cnt <= MULDIV_LAT-2`, state becomes MULDIV. In MULDIV: `cnt <= cnt-1`.
     - MULDIV with `cnt=0`: muldiv_done=1, no stall, state becomes RUN.
     - MULDIV_LAT=1: muldiv_done=1 in the same cycle and the FSM stays in RUN.
  3. Branch (`ex_branch_taken`):
     - if_id_flush=1, id_ex_flush=1, pc_stall=0 (the redirect always loads the PC); flush_cnt increments.
     - If `imem_ready=0` in the same cycle, set `kill_pending`.
  4. Load-use:
     - Condition: `ex_mem_read && ex_rd≠0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))`.
     - pc_stall=1, if_id_stall=1, id_ex_flush=1. if_id_flush is forced to 0, so the ID instruction is preserved.
  5. IMEM wait (`!imem_ready`):
     - pc_stall=1, if_id_flush=1 (a NOP enters ID).
     - Under rule 4: pc_stall only; rule 4's if_id_flush=0 still holds.
  6. Stale fetch (`kill_pending && imem_ready`, not under rules 1–3):
     - The arriving word belongs to the pre-redirect PC.
     - if_id_flush=1, pc_stall=1, clear `kill_pending`. The fetcher then re-issues at the redirected PC.
- Counters:
  - stall_cnt increments on every cycle with pc_stall=1.
  - flush_cnt increments on each rule-3 cycle.
  - Both saturate at all-ones and are registered.

## Timing
- Reset (async):
  - State RUN, `cnt=0`, `kill_pending=0`, stall_cnt=0, flush_cnt=0.
  - Control outputs then follow the inputs combinationally; no post-reset stall is inserted.
- Zero-cycle decision latency: the controls act on the next clk edge of the pipeline registers.
- A load-use hazard costs exactly 1 bubble.
- A mul/div occupies EX for MULDIV_LAT cycles and stalls for MULDIV_LAT-1 cycles, plus any DMEM-wait cycles.
- A branch costs 2 bubbles, plus 1 extra fetch cycle if it hits an outstanding fetch.
- Reset asserted mid-MULDIV or with `kill_pending` set aborts immediately to the reset state.

## Test plan
- Load-use: EX `lw x5`, ID `add x6,x5,x1`:
  - 1 cycle with pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - Next cycle all controls are 0; stall_cnt=1.
  - The same sequence with `ex_rd=0` produces no stall.
- Mul/div, MULDIV_LAT=4, ex_muldiv held high: 3 stall cycles with ex_mem_flush=1, then muldiv_done=1 on the 4th; state returns to RUN.
- DMEM wait held 2 cycles during MULDIV stall cycle 2:
  - All stalls plus mem_wb_flush for 2 cycles.
  - `cnt` is frozen; muldiv_done arrives 2 cycles later than without the wait.
- Branch with imem_ready=1:
  - if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_cnt=1.
  - Branch in the same cycle as a load-use condition: branch wins, pc_stall=0.
- Branch with imem_ready=0:
  - `kill_pending` is set.
  - The next imem_ready=1 cycle gives if_id_flush=1, pc_stall=1.
  - The following imem_ready=1 cycle gives all controls 0.
- Assert rst_n low during MULDIV cycle 2 with `kill_pending=1`: state RUN, counters 0, no kill on the next fetch.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard inputs from the pipeline stages and
// the stall/flush controls and performance counters going back.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_muldiv;
    logic             ex_branch_taken;
    logic             imem_ready;
    logic             mem_access;
    logic             dmem_ready;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             muldiv_done;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_muldiv, ex_branch_taken, imem_ready, mem_access, dmem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mem_wb_flush, muldiv_done,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
               ex_muldiv, ex_branch_taken, imem_ready, mem_access, dmem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, ex_mem_flush, mem_wb_flush, muldiv_done,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline, with saturating
// stall/flush event counters.
//
// state  | meaning
// RUN    | normal issue; a mul/div entering EX starts the occupancy count
// MULDIV | mul/div held in EX; cnt = remaining stall cycles before the done cycle
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int            CW       = $clog2(MULDIV_LAT) + 1;
    localparam bit            MD_MULTI = (MULDIV_LAT > 1);
    localparam logic [CW-1:0] CNT_INIT = MD_MULTI ? CW'(MULDIV_LAT - 2) : '0;

    typedef enum logic {RUN, MULDIV} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           kill_pending;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic dmem_wait, load_use, md_stall, free_run;
    logic br_act, lu_act, stale_act;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, ex_mem_flush, mem_wb_flush, muldiv_done;

    always_comb begin
        dmem_wait = hz.mem_access && !hz.dmem_ready;
        load_use  = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
        md_stall  = ((state == RUN) && hz.ex_muldiv && MD_MULTI) ||
                    ((state == MULDIV) && (cnt != '0));
        free_run  = !dmem_wait && !md_stall;
        br_act    = free_run && hz.ex_branch_taken;
        lu_act    = free_run && !hz.ex_branch_taken && load_use;
        stale_act = free_run && !hz.ex_branch_taken && !load_use &&
                    kill_pending && hz.imem_ready;

        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        muldiv_done  = 1'b0;

        if (dmem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (md_stall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            muldiv_done = ((state == MULDIV) && (cnt == '0)) ||
                          ((state == RUN) && hz.ex_muldiv && !MD_MULTI);
            // The redirect always loads the PC, even if the fetch is still outstanding.
            if (br_act) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_act) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else if (!hz.imem_ready || stale_act) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= '0;
            kill_pending <= 1'b0;
        end else if (!dmem_wait) begin
            case (state)
                RUN: begin
                    if (hz.ex_muldiv && MD_MULTI) begin
                        state <= MULDIV;
                        cnt   <= CNT_INIT;
                    end
                end
                MULDIV: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           state <= RUN;
                end
                default: state <= RUN;
            endcase
            // A branch that finds the fetch already complete has nothing stale to kill.
            if (br_act)         kill_pending <= !hz.imem_ready;
            else if (stale_act) kill_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (br_act && (flush_cnt != '1))   flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.pc_stall     = pc_stall;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_stall  = id_ex_stall;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_stall = ex_mem_stall;
    assign hz.ex_mem_flush = ex_mem_flush;
    assign hz.mem_wb_flush = mem_wb_flush;
    assign hz.muldiv_done  = muldiv_done;
    assign hz.stall_cnt    = stall_cnt;
    assign hz.flush_cnt    = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table from reset, directed multi-cycle
// sequences, randomized traffic against a reference model, counter saturation.
module tb_hazard_ctrl;
    localparam int LAT   = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // control word bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
    // id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush, muldiv_done
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_DMEM = 9'b110101010;
    localparam logic [8:0] C_MD   = 9'b110100100;
    localparam logic [8:0] C_DONE = 9'b000000001;
    localparam logic [8:0] C_BR   = 9'b001010000;
    localparam logic [8:0] C_LU   = 9'b110010000;
    localparam logic [8:0] C_IMEM = 9'b101000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
    hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

    int checks = 0;
    int failures = 0;

    // reference model: remaining EX cycles of the current mul/div, kill flag, counters
    int m_left, m_stall, m_flush;
    bit m_kill;

    typedef struct {
        logic       ma, dr, md, br, ir, mr;
        logic [4:0] rd, r1, r2;
        logic       u1, u2;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[12];

    function automatic logic [8:0] dut_ctrl();
        return {hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_stall, hz.id_ex_flush,
                hz.ex_mem_stall, hz.ex_mem_flush, hz.mem_wb_flush, hz.muldiv_done};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ma, dr, md, br, ir, mr, input logic [4:0] rd, r1, r2,
                         input logic u1, u2);
        hz.mem_access = ma; hz.dmem_ready = dr; hz.ex_muldiv = md;
        hz.ex_branch_taken = br; hz.imem_ready = ir; hz.ex_mem_read = mr;
        hz.ex_rd = rd; hz.id_rs1 = r1; hz.id_rs2 = r2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
    endtask

    task automatic idle();
        drive(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic model_reset();
        m_left = 0; m_kill = 0; m_stall = 0; m_flush = 0;
    endtask

    // called at a negedge: pulse reset asynchronously
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic model_eval(output logic [8:0] o, output int nl, output bit nk,
                              output bit br);
        bit dw, lu;
        int left;
        o = C_NONE; nl = m_left; nk = m_kill; br = 0;
        dw = hz.mem_access && !hz.dmem_ready;
        lu = hz.ex_mem_read && (hz.ex_rd != 0) &&
             ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        left = (m_left > 0) ? m_left : (hz.ex_muldiv ? LAT : 0);
        if (dw) begin
            o = C_DMEM;
        end else begin
            nl = (left > 0) ? left - 1 : 0;
            if (left > 1) begin
                o = C_MD;
            end else begin
                if (left == 1) o = C_DONE;
                if (hz.ex_branch_taken) begin
                    o = o | C_BR; br = 1; nk = !hz.imem_ready;
                end else if (lu) begin
                    o = o | C_LU;
                end else if (!hz.imem_ready) begin
                    o = o | C_IMEM;
                end else if (m_kill) begin
                    o = o | C_IMEM; nk = 0;
                end
            end
        end
    endtask

    // called at a negedge after inputs are driven; checks, then advances one clock
    task automatic step(input string nm, input bit has_exp, input logic [8:0] exp);
        logic [8:0] o;
        int nl;
        bit nk, br;
        #1;
        model_eval(o, nl, nk, br);
        if (has_exp) chk({nm, "_ctrl"}, {23'd0, dut_ctrl()}, {23'd0, exp});
        chk({nm, "_model"}, {23'd0, dut_ctrl()}, {23'd0, o});
        chk({nm, "_stall_cnt"}, {24'd0, hz.stall_cnt}, m_stall);
        chk({nm, "_flush_cnt"}, {24'd0, hz.flush_cnt}, m_flush);
        @(posedge clk);
        m_left = nl;
        m_kill = nk;
        if (o[8] && m_stall < CMAX) m_stall++;
        if (br && m_flush < CMAX) m_flush++;
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single-cycle decisions from the reset state
        vecs[0]  = '{0,1,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, C_NONE};
        vecs[1]  = '{1,0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, C_DMEM};
        vecs[2]  = '{0,1,1,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, C_MD};
        vecs[3]  = '{0,1,0,1,1,0, 5'd0, 5'd0, 5'd0, 0,0, C_BR};
        vecs[4]  = '{0,1,0,0,1,1, 5'd5, 5'd5, 5'd1, 1,1, C_LU};
        vecs[5]  = '{0,1,0,0,1,1, 5'd0, 5'd0, 5'd1, 1,1, C_NONE};
        vecs[6]  = '{0,1,0,0,0,1, 5'd7, 5'd2, 5'd7, 1,1, C_LU};
        vecs[7]  = '{0,1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, C_IMEM};
        vecs[8]  = '{0,1,0,1,1,1, 5'd5, 5'd5, 5'd1, 1,1, C_BR};
        vecs[9]  = '{1,0,0,1,1,1, 5'd5, 5'd5, 5'd1, 1,1, C_DMEM};
        vecs[10] = '{0,1,0,0,1,1, 5'd9, 5'd1, 5'd9, 1,0, C_NONE};
        vecs[11] = '{1,1,1,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, C_MD};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            do_reset();
            drive(vecs[i].ma, vecs[i].dr, vecs[i].md, vecs[i].br, vecs[i].ir, vecs[i].mr,
                  vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].u1, vecs[i].u2);
            #1;
            chk($sformatf("vec%0d", i), {23'd0, dut_ctrl()}, {23'd0, vecs[i].exp});
        end

        // load-use: one bubble, then clean; ex_rd=0 never stalls
        @(negedge clk); idle(); do_reset();
        drive(0, 1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd1, 1, 1);
        step("lu", 1, C_LU);
        idle();
        #1 chk("lu_stall_cnt1", {24'd0, hz.stall_cnt}, 32'd1);
        step("lu_after", 1, C_NONE);
        drive(0, 1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd1, 1, 1);
        step("lu_x0", 1, C_NONE);

        // mul/div: 3 stall cycles then done, back in RUN
        idle(); do_reset();
        hz.ex_muldiv = 1'b1;
        for (int i = 0; i < LAT - 1; i++) step($sformatf("md_stall%0d", i), 1, C_MD);
        step("md_done", 1, C_DONE);
        hz.ex_muldiv = 1'b0;
        step("md_run", 1, C_NONE);

        // DMEM wait for 2 cycles during mul/div stall cycle 2 delays done by 2
        idle(); do_reset();
        hz.ex_muldiv = 1'b1;
        step("mdw_s0", 1, C_MD);
        hz.mem_access = 1'b1; hz.dmem_ready = 1'b0;
        step("mdw_w0", 1, C_DMEM);
        step("mdw_w1", 1, C_DMEM);
        hz.dmem_ready = 1'b1;
        step("mdw_s1", 1, C_MD);
        step("mdw_s2", 1, C_MD);
        step("mdw_done", 1, C_DONE);

        // branch with fetch complete, and branch beating load-use
        idle(); do_reset();
        hz.ex_branch_taken = 1'b1;
        step("br", 1, C_BR);
        idle();
        #1 chk("br_flush_cnt1", {24'd0, hz.flush_cnt}, 32'd1);
        drive(0, 1, 0, 1, 1, 1, 5'd5, 5'd5, 5'd1, 1, 1);
        step("br_lu", 1, C_BR);

        // branch hitting an outstanding fetch: stale word killed, then clean
        idle(); do_reset();
        hz.ex_branch_taken = 1'b1; hz.imem_ready = 1'b0;
        step("brk", 1, C_BR);
        hz.ex_branch_taken = 1'b0;
        step("brk_wait", 1, C_IMEM);
        hz.imem_ready = 1'b1;
        step("brk_stale", 1, C_IMEM);
        step("brk_clean", 1, C_NONE);

        // reset mid-mul/div with a pending kill aborts everything
        idle(); do_reset();
        hz.ex_branch_taken = 1'b1; hz.imem_ready = 1'b0;
        step("rst_br", 1, C_BR);
        hz.ex_branch_taken = 1'b0; hz.imem_ready = 1'b1; hz.ex_muldiv = 1'b1;
        step("rst_md0", 1, C_MD);
        do_reset();
        idle();
        #1 chk("rst_stall_cnt0", {24'd0, hz.stall_cnt}, 32'd0);
        chk("rst_flush_cnt0", {24'd0, hz.flush_cnt}, 32'd0);
        step("rst_nokill", 1, C_NONE);

        // randomized traffic against the model
        idle(); do_reset();
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            step("rnd", 0, C_NONE);
        end

        // counter saturation
        idle(); do_reset();
        hz.imem_ready = 1'b0;
        repeat (CMAX + 10) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("stall_sat", {24'd0, hz.stall_cnt}, CMAX);
        idle(); do_reset();
        hz.ex_branch_taken = 1'b1;
        repeat (CMAX + 10) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("flush_sat", {24'd0, hz.flush_cnt}, CMAX);
        chk("flush_sat_stall0", {24'd0, hz.stall_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
